// File: rtl/rom_ctrl_compare_pkg.sv
// Shared types and helpers for the multi-lane ROM digest comparator.
// State encodings keep a pairwise Hamming distance of at least 3.
package rom_ctrl_compare_pkg;

  typedef enum logic [4:0] {
    StIdle   = 5'b10110,
    StStream = 5'b01101,
    StDone   = 5'b11011,
    StError  = 5'b00000
  } state_e;

  typedef logic [3:0] mubi4_t;
  parameter mubi4_t MuBi4True  = 4'h6;
  parameter mubi4_t MuBi4False = 4'h9;

  function automatic mubi4_t mubi4_bool_to_mubi(input logic b);
    return b ? MuBi4True : MuBi4False;
  endfunction

  // Width needed to index n items; never less than one bit.
  function automatic int unsigned vbits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned num_beats(input int unsigned words, input int unsigned lanes);
    return (words + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/rom_ctrl_compare_beat.sv
// Combinational beat slicer: selects the lanes of one beat, masks lanes past the
// end of the digest and reports equality plus the lowest mismatching word index.
module rom_ctrl_compare_beat
  import rom_ctrl_compare_pkg::*;
#(
  parameter int unsigned NumWords      = 8,
  parameter int unsigned WordW         = 32,
  parameter int unsigned LanesPerCycle = 2,
  parameter int unsigned BeatW         = 2,
  parameter int unsigned IdxW          = 3
) (
  input  logic [NumWords*WordW-1:0]      digest_i,
  input  logic [NumWords*WordW-1:0]      exp_digest_i,
  input  logic [BeatW-1:0]               beat_i,
  output logic [LanesPerCycle*WordW-1:0] data_o,
  output logic [LanesPerCycle-1:0]       mask_o,
  output logic                           match_o,
  output logic [IdxW-1:0]                first_idx_o
);

  logic found;

  // Lanes are scanned in ascending order, so the first hit is the lowest word index.
  always_comb begin
    data_o      = '0;
    mask_o      = '0;
    match_o     = 1'b1;
    first_idx_o = '0;
    found       = 1'b0;
    for (int unsigned l = 0; l < LanesPerCycle; l++) begin
      for (int unsigned w = 0; w < NumWords; w++) begin
        if (w == 32'(beat_i) * LanesPerCycle + l) begin
          data_o[l*WordW +: WordW] = digest_i[w*WordW +: WordW];
          mask_o[l]                = 1'b1;
          if (digest_i[w*WordW +: WordW] != exp_digest_i[w*WordW +: WordW]) begin
            match_o = 1'b0;
            if (!found) begin
              found       = 1'b1;
              first_idx_o = IdxW'(w);
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/rom_ctrl_compare_stream.sv
// Walks computed vs expected digests a beat at a time, streams the computed digest
// to keymgr over valid/ready, and reports a sticky match result plus alerts.
module rom_ctrl_compare_stream
  import rom_ctrl_compare_pkg::*;
#(
  parameter int unsigned NumWords      = 8,
  parameter int unsigned WordW         = 32,
  parameter int unsigned LanesPerCycle = 2,
  parameter bit          EarlyAbort    = 1'b0,
  localparam int unsigned NumBeats     = num_beats(NumWords, LanesPerCycle),
  localparam int unsigned AW           = vbits(NumWords),
  localparam int unsigned BW           = vbits(NumBeats)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [NumWords*WordW-1:0]      digest_i,
  input  logic [NumWords*WordW-1:0]      exp_digest_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [LanesPerCycle*WordW-1:0] out_data_o,
  output logic [LanesPerCycle-1:0]       out_mask_o,
  output logic                           out_last_o,
  output logic                           done_o,
  output mubi4_t                         good_o,
  output logic [AW-1:0]                  mismatch_idx_o,
  output logic                           alert_o
);

  localparam logic [BW-1:0] LastBeat = BW'(NumBeats - 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [BW-1:0]   beat_n_q, beat_n_d;
  logic            matches_q, matches_d;
  logic [AW-1:0]   mismatch_idx_q, mismatch_idx_d;
  mubi4_t          good_q, good_d;
  logic            alert_q, alert_d;

  logic [LanesPerCycle*WordW-1:0] beat_data;
  logic [LanesPerCycle-1:0]       beat_mask;
  logic                           beat_match;
  logic [AW-1:0]                  beat_first_idx;
  logic                           transfer, is_last, abort, cnt_err;

  rom_ctrl_compare_beat #(
    .NumWords      (NumWords),
    .WordW         (WordW),
    .LanesPerCycle (LanesPerCycle),
    .BeatW         (BW),
    .IdxW          (AW)
  ) u_beat (
    .digest_i     (digest_i),
    .exp_digest_i (exp_digest_i),
    .beat_i       (beat_q),
    .data_o       (beat_data),
    .mask_o       (beat_mask),
    .match_o      (beat_match),
    .first_idx_o  (beat_first_idx)
  );

  assign transfer = (state_q == StStream) && out_ready_i;
  assign is_last  = (beat_q == LastBeat);
  assign abort    = EarlyAbort && !beat_match;
  // Counter is held alongside an inverted copy; any disagreement is a fault.
  assign cnt_err  = (beat_q != ~beat_n_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start_i) state_d = StStream;
      StStream: if (transfer && (is_last || abort)) state_d = StDone;
      StDone:   state_d = StDone;
      StError:  state_d = StError;
      default:  state_d = StError;
    endcase
  end

  always_comb begin
    beat_d         = beat_q;
    beat_n_d       = beat_n_q;
    matches_d      = matches_q;
    mismatch_idx_d = mismatch_idx_q;
    if (transfer) begin
      matches_d = matches_q & beat_match;
      if (matches_q && !beat_match) mismatch_idx_d = beat_first_idx;
      if (!is_last) begin
        beat_d   = beat_q + 1'b1;
        beat_n_d = beat_n_q - 1'b1;
      end
    end
    good_d  = (state_q == StDone) ? mubi4_bool_to_mubi(matches_q) : MuBi4False;
    alert_d = alert_q
            | (state_q == StError)
            | (start_i && (state_q != StIdle))
            | ((state_q == StIdle) && (beat_q != '0))
            | (transfer && is_last && (~beat_n_q != LastBeat))
            | cnt_err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q         <= '0;
      beat_n_q       <= '1;
      matches_q      <= 1'b1;
      mismatch_idx_q <= '1;
      good_q         <= MuBi4False;
      alert_q        <= 1'b0;
    end else begin
      beat_q         <= beat_d;
      beat_n_q       <= beat_n_d;
      matches_q      <= matches_d;
      mismatch_idx_q <= mismatch_idx_d;
      good_q         <= good_d;
      alert_q        <= alert_d;
    end
  end

  // good_q is masked by Done so a late state fault can never leave True visible.
  always_comb begin
    out_valid_o    = (state_q == StStream);
    out_data_o     = beat_data;
    out_mask_o     = beat_mask;
    out_last_o     = (state_q == StStream) && is_last;
    done_o         = (state_q == StDone);
    good_o         = (state_q == StDone) ? good_q : MuBi4False;
    mismatch_idx_o = mismatch_idx_q;
    alert_o        = alert_q;
  end

endmodule

// File: tb/tb_rom_ctrl_compare_stream.sv
// Scoreboard bench: expected beats are queued by the stimulus, a negedge monitor
// pops and compares each accepted beat; result outputs are checked directly.
module tb_rom_ctrl_compare_stream;
  import rom_ctrl_compare_pkg::*;

  localparam logic [3:0] GT = 4'h6;
  localparam logic [3:0] GF = 4'h9;

  typedef struct {
    logic [95:0] data;
    logic [2:0]  mask;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [255:0] dig, a_dig, a_exp, b_dig, b_exp;
  logic [31:0]  c_dig, c_exp;
  logic a_start, a_ready, b_start, b_ready, c_start, c_ready;
  logic a_valid, a_last, a_done, a_alert;
  logic b_valid, b_last, b_done, b_alert;
  logic c_valid, c_last, c_done, c_alert;
  logic [95:0] a_data, b_data;
  logic [31:0] c_data;
  logic [2:0]  a_mask, b_mask, a_idx, b_idx;
  logic [0:0]  c_mask, c_idx;
  logic [3:0]  a_good, b_good, c_good;

  rom_ctrl_compare_stream #(.NumWords(8), .WordW(32), .LanesPerCycle(3), .EarlyAbort(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .digest_i(a_dig), .exp_digest_i(a_exp),
    .out_valid_o(a_valid), .out_ready_i(a_ready), .out_data_o(a_data), .out_mask_o(a_mask),
    .out_last_o(a_last), .done_o(a_done), .good_o(a_good), .mismatch_idx_o(a_idx), .alert_o(a_alert));

  rom_ctrl_compare_stream #(.NumWords(8), .WordW(32), .LanesPerCycle(3), .EarlyAbort(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .digest_i(b_dig), .exp_digest_i(b_exp),
    .out_valid_o(b_valid), .out_ready_i(b_ready), .out_data_o(b_data), .out_mask_o(b_mask),
    .out_last_o(b_last), .done_o(b_done), .good_o(b_good), .mismatch_idx_o(b_idx), .alert_o(b_alert));

  rom_ctrl_compare_stream #(.NumWords(1), .WordW(32), .LanesPerCycle(1), .EarlyAbort(1'b0)) dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(c_start), .digest_i(c_dig), .exp_digest_i(c_exp),
    .out_valid_o(c_valid), .out_ready_i(c_ready), .out_data_o(c_data), .out_mask_o(c_mask),
    .out_last_o(c_last), .done_o(c_done), .good_o(c_good), .mismatch_idx_o(c_idx), .alert_o(c_alert));

  beat_t qa[$], qb[$], qc[$];
  int    ta = 0, tbn = 0, tc = 0;
  beat_t held;
  logic  a_stalled = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] w(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  task automatic push_beat(input int id, input logic [95:0] d, input logic [2:0] m, input logic l);
    beat_t e;
    e.data = d; e.mask = m; e.last = l;
    if (id == 0) qa.push_back(e);
    else if (id == 1) qb.push_back(e);
    else qc.push_back(e);
  endtask

  // Hand-packed beats of the 8-word digest at 3 lanes per beat.
  task automatic push_full(input int id, input int n);
    if (n > 0) push_beat(id, {w(2), w(1), w(0)}, 3'b111, 1'b0);
    if (n > 1) push_beat(id, {w(5), w(4), w(3)}, 3'b111, 1'b0);
    if (n > 2) push_beat(id, {32'h0, w(7), w(6)}, 3'b011, 1'b1);
  endtask

  task automatic pop_cmp(input int id, input logic [95:0] d, input logic [2:0] m, input logic l);
    beat_t e;
    int    sz;
    sz = (id == 0) ? qa.size() : (id == 1) ? qb.size() : qc.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_beat dut%0d: got data %0h, required no beat", id, d);
    end else begin
      if (id == 0) e = qa.pop_front();
      else if (id == 1) e = qb.pop_front();
      else e = qc.pop_front();
      check("beat_data", d, e.data);
      check("beat_mask", 96'(m), 96'(e.mask));
      check("beat_last", 96'(l), 96'(e.last));
    end
  endtask

  always @(negedge clk) begin
    if (!rst && a_valid) begin
      if (a_stalled) begin
        check("hold_data", a_data, held.data);
        check("hold_mask", 96'(a_mask), 96'(held.mask));
        check("hold_last", 96'(a_last), 96'(held.last));
      end
      if (a_ready) begin
        pop_cmp(0, a_data, a_mask, a_last);
        ta++;
        a_stalled = 1'b0;
      end else begin
        a_stalled = 1'b1;
        held.data = a_data; held.mask = a_mask; held.last = a_last;
      end
    end else begin
      a_stalled = 1'b0;
    end
    if (!rst && b_valid && b_ready) begin
      pop_cmp(1, b_data, b_mask, b_last);
      tbn++;
    end
    if (!rst && c_valid && c_ready) begin
      pop_cmp(2, 96'(c_data), 3'(c_mask), c_last);
      tc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_start(input int id, input logic v);
    if (id == 0) a_start = v; else if (id == 1) b_start = v; else c_start = v;
  endtask

  task automatic set_ready(input int id, input logic v);
    if (id == 0) a_ready = v; else if (id == 1) b_ready = v; else c_ready = v;
  endtask

  function automatic logic get_done(input int id);
    return (id == 0) ? a_done : (id == 1) ? b_done : c_done;
  endfunction

  function automatic logic [3:0] get_good(input int id);
    return (id == 0) ? a_good : (id == 1) ? b_good : c_good;
  endfunction

  function automatic logic [2:0] get_idx(input int id);
    return (id == 0) ? a_idx : (id == 1) ? b_idx : 3'(c_idx);
  endfunction

  function automatic logic get_alert(input int id);
    return (id == 0) ? a_alert : (id == 1) ? b_alert : c_alert;
  endfunction

  // cyc counts rising edges from the start_i edge until done_o is seen.
  task automatic run(input int id, input logic [5:0] pat, input int restart_at, output int cyc);
    logic dn;
    cyc = 0;
    set_start(id, 1'b1);
    do begin
      tick();
      cyc++;
      set_start(id, cyc == restart_at);
      set_ready(id, (cyc <= 6) ? pat[cyc-1] : 1'b1);
      dn = get_done(id);
    end while (!dn && cyc < 60);
    if (!dn) begin
      checks++;
      errors++;
      $display("FAIL done_timeout dut%0d: got no done_o after %0d cycles, required done_o", id, cyc);
    end
  endtask

  task automatic check_result(input int id, input logic [2:0] idx, input logic [3:0] good, input logic alert);
    check("good_first_done_cycle", 96'(get_good(id)), 96'(GF));
    tick();
    check("done_held", 96'(get_done(id)), 96'(1));
    check("good", 96'(get_good(id)), 96'(good));
    check("mismatch_idx", 96'(get_idx(id)), 96'(idx));
    check("alert", 96'(get_alert(id)), 96'(alert));
  endtask

  initial begin
    int cyc, t0;
    rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
    for (int k = 0; k < 8; k++) dig[k*32 +: 32] = w(k);
    a_dig = dig; a_exp = dig;
    b_dig = dig; b_exp = dig;
    b_exp[4*32 +: 32] = w(4) ^ 32'h0000_0100;
    c_dig = 32'h1234_5678; c_exp = 32'h1234_5679;

    do_reset();
    check("rst_valid", 96'(a_valid), 96'(0));
    check("rst_done", 96'(a_done), 96'(0));
    check("rst_good", 96'(a_good), 96'(GF));
    check("rst_idx", 96'(a_idx), 96'(3'h7));
    check("rst_alert", 96'(a_alert), 96'(0));
    check("rst_idx_c", 96'(c_idx), 96'(1));

    // Equal digests, no backpressure.
    push_full(0, 3);
    t0 = ta;
    run(0, 6'b111111, 0, cyc);
    check("latency_equal", 96'(cyc), 96'(4));
    check_result(0, 3'd7, GT, 1'b0);
    check("transfers_equal", 96'(ta - t0), 96'(3));

    // Word 4 differs.
    do_reset();
    a_exp[4*32 +: 32] = w(4) ^ 32'h0000_0100;
    push_full(0, 3);
    run(0, 6'b111111, 0, cyc);
    check("latency_mismatch", 96'(cyc), 96'(4));
    check_result(0, 3'd4, GF, 1'b0);

    // Backpressure 0,0,1,0,1,1 on the same mismatching digest.
    do_reset();
    push_full(0, 3);
    t0 = ta;
    run(0, 6'b110100, 0, cyc);
    check("latency_stall", 96'(cyc), 96'(7));
    check_result(0, 3'd4, GF, 1'b0);
    check("transfers_stall", 96'(ta - t0), 96'(3));

    // Illegal start_i while streaming.
    do_reset();
    a_exp = dig;
    push_full(0, 3);
    run(0, 6'b111111, 1, cyc);
    check("latency_restart", 96'(cyc), 96'(4));
    check_result(0, 3'd7, GT, 1'b1);

    // Invalid state encoding.
    do_reset();
    @(negedge clk);
    force dut_a.state_q = state_e'(5'h1F);
    @(negedge clk);
    release dut_a.state_q;
    tick();
    tick();
    check("err_alert", 96'(a_alert), 96'(1));
    check("err_good", 96'(a_good), 96'(GF));
    check("err_done", 96'(a_done), 96'(0));
    check("err_valid", 96'(a_valid), 96'(0));

    // Reset while beat 1 is pending, then a clean rerun.
    do_reset();
    push_full(0, 1);
    a_start = 1'b1;
    a_ready = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    a_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 96'(a_valid), 96'(0));
    check("midrst_done", 96'(a_done), 96'(0));
    check("midrst_good", 96'(a_good), 96'(GF));
    check("midrst_idx", 96'(a_idx), 96'(3'h7));
    check("midrst_alert", 96'(a_alert), 96'(0));
    check("midrst_queue", 96'(qa.size()), 96'(0));
    a_ready = 1'b1;
    push_full(0, 3);
    run(0, 6'b111111, 0, cyc);
    check("latency_rerun", 96'(cyc), 96'(4));
    check_result(0, 3'd7, GT, 1'b0);

    // EarlyAbort: stop after beat 1.
    do_reset();
    push_full(1, 2);
    t0 = tbn;
    run(1, 6'b111111, 0, cyc);
    check("latency_abort", 96'(cyc), 96'(3));
    check_result(1, 3'd4, GF, 1'b0);
    tick();
    tick();
    check("transfers_abort", 96'(tbn - t0), 96'(2));

    // Single word, single lane.
    do_reset();
    push_beat(2, 96'(32'h1234_5678), 3'b001, 1'b1);
    t0 = tc;
    run(2, 6'b111111, 0, cyc);
    check("latency_single", 96'(cyc), 96'(2));
    check_result(2, 3'd0, GF, 1'b0);
    check("transfers_single", 96'(tc - t0), 96'(1));

    check("queue_a_left", 96'(qa.size()), 96'(0));
    check("queue_b_left", 96'(qb.size()), 96'(0));
    check("queue_c_left", 96'(qc.size()), 96'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
